dmem_bridge: RTL and testbench
==============================

// Module: dmem_bridge
// PURPOSE
//  Data-memory slave on the CPU's MEM-stage data port: consumes addr/wr/mask/data/rd, returns read data + valid.
//  Holds a byte-maskable word array; writes complete in one cycle, reads take READ_LATENCY cycles.
//  op_busy backpressure lets the pipeline stall on multi-cycle reads.
// PARAMETERS
//  DEPTH_WORDS   1024          number of 32-bit words (power of 2, >=4)
//  READ_LATENCY  1             cycles from accepted rd to op_data_valid (1..7)
//  BASE_ADDR     32'h0000_0000 byte address mapped to word 0
// PORTS
//  clk                input   1   clock, rising edge
//  reset              input   1   asynchronous, active-high reset
//  ip_data_addr       input   32  byte address (low 2 bits ignored for indexing)
//  ip_data_wr         input   1   write request
//  ip_data_mask       input   4   byte enables; bit n -> byte lane n
//  ip_data_from_proc  input   32  write data, already lane-aligned
//  ip_data_rd         input   1   read request
//  op_data_valid      output  1   one-cycle pulse: op_data_to_proc is valid
//  op_data_to_proc    output  32  full read word (CPU does byte/half extraction)
//  op_busy            output  1   high while a read is in flight; requests ignored
//  op_data_err        output  1   only with DMEM_ERR_EN; see CONFIGURATION
// BEHAVIOUR
//  - Reset values: op_data_valid=0, op_data_to_proc=0, op_busy=0, op_data_err=0, FSM=IDLE, counter=0.
//    Array contents not cleared by reset.
//  - Index: off=ip_data_addr-BASE_ADDR (32-bit wrap);
//    in_range = off[31:2] < DEPTH_WORDS; idx = off[$clog2(DEPTH_WORDS)+1:2].
//  - FSM IDLE:
//    - Requests sampled only in IDLE (op_busy=0).
//    - wr=1: at the edge, bytes with mask=1 are written; others kept. No response pulse.
//    - wr=1 & rd=1 together: write performed, read dropped; no valid.
//    - rd=1 (wr=0): latch idx/in_range.
//      - READ_LATENCY=1: -> RESP.
//      - else -> WAIT with cnt=READ_LATENCY-2.
//  - FSM WAIT: op_busy=1; cnt decrements each cycle; cnt==0 -> RESP.
//  - FSM RESP: op_data_valid=1 for exactly one cycle.
//    - op_data_to_proc = mem[idx] if in_range else 32'h0.
//    - op_busy=0 in RESP; a request in this cycle is accepted (back-to-back reads every READ_LATENCY cycles).
//    - Next state per IDLE rules.
//  - op_data_to_proc holds its last value after the valid pulse (changes only on the next RESP).
//  - Latency: rd accepted at edge N -> op_data_valid high in cycle N+READ_LATENCY.
//  - Read data is the array value at the RESP edge, including a write accepted in the same RESP cycle?
//    No: RESP data is registered first; the write lands after (read-before-write).
//  - Out-of-range write: dropped, no array change. Out-of-range read: completes normally, data 0.
//  - Requests during WAIT (op_busy=1): ignored entirely, including writes; the caller must hold them.
//  - Reset mid-read: FSM->IDLE immediately (async); pending response discarded, no valid pulse.
//  - mask=4'b0000 with wr=1: legal no-op.
// CONFIGURATION
//  DMEM_ERR_EN defined:
//    - op_data_err port exists.
//    - Pulses with op_data_valid on an out-of-range read.
//    - Pulses one cycle after an accepted out-of-range write.
//  DMEM_ERR_EN undefined: op_data_err port absent; out-of-range behaviour otherwise identical.
// TESTING
//  wr addr 0x10 mask 1111 data 0xDEADBEEF; rd 0x10 -> valid at N+READ_LATENCY, data 0xDEADBEEF
//  then wr 0x11 mask 0010 data 0x0000AB00; rd 0x10 -> 0xDEADABEF
//  READ_LATENCY=3: rd 0x10, rd 0x14 held during busy -> op_busy 2 cycles, one valid; 0x14 read only after accept
//  wr+rd same cycle to 0x20 data 0x12345678 -> no valid; later rd 0x20 -> 0x12345678
//  rd addr BASE_ADDR+4*DEPTH_WORDS -> data 0, valid; DMEM_ERR_EN: op_data_err=1 with valid
//  READ_LATENCY=4, reset asserted 2 cycles after rd -> no valid pulse, outputs 0, prior array data intact

Source files
------------

// File: rtl/dmem_bridge_if.sv
// CPU data-port bundle between the MEM stage (master) and the data memory (slave).
// op_data_err is present only when DMEM_ERR_EN is defined.
interface dmem_bridge_if;
  logic [31:0] ip_data_addr;
  logic        ip_data_wr;
  logic [3:0]  ip_data_mask;
  logic [31:0] ip_data_from_proc;
  logic        ip_data_rd;
  logic        op_data_valid;
  logic [31:0] op_data_to_proc;
  logic        op_busy;
`ifdef DMEM_ERR_EN
  logic        op_data_err;

  modport master (
    output ip_data_addr, ip_data_wr, ip_data_mask, ip_data_from_proc, ip_data_rd,
    input  op_data_valid, op_data_to_proc, op_busy, op_data_err
  );

  modport slave (
    input  ip_data_addr, ip_data_wr, ip_data_mask, ip_data_from_proc, ip_data_rd,
    output op_data_valid, op_data_to_proc, op_busy, op_data_err
  );
`else
  modport master (
    output ip_data_addr, ip_data_wr, ip_data_mask, ip_data_from_proc, ip_data_rd,
    input  op_data_valid, op_data_to_proc, op_busy
  );

  modport slave (
    input  ip_data_addr, ip_data_wr, ip_data_mask, ip_data_from_proc, ip_data_rd,
    output op_data_valid, op_data_to_proc, op_busy
  );
`endif
endinterface

// File: rtl/dmem_bridge.sv
// Byte-maskable data memory on the CPU MEM-stage port: single-cycle writes, READ_LATENCY-cycle reads.
// Define DMEM_ERR_EN to add the op_data_err out-of-range indication.
module dmem_bridge #(
  parameter int          DEPTH_WORDS  = 1024,
  parameter int          READ_LATENCY = 1,
  parameter logic [31:0] BASE_ADDR    = 32'h0000_0000
) (
  input  logic         clk,
  input  logic         reset,
  dmem_bridge_if.slave bus
);

  localparam int IDX_W = $clog2(DEPTH_WORDS);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t           state, state_next;
  logic [2:0]       cnt, cnt_next;
  logic [IDX_W-1:0] idx_q;
  logic             in_range_q;
  logic [31:0]      off;
  logic [IDX_W-1:0] idx;
  logic             in_range;
  logic             accept;
  logic             take_wr;
  logic             take_rd;
  logic [IDX_W-1:0] rd_idx;
  logic             rd_in_range;
  logic             valid_q;
  logic [31:0]      data_q;
  logic [31:0]      mem [DEPTH_WORDS];

  // Offset wraps mod 2^32, so addresses below BASE_ADDR land far out of range.
  assign off      = bus.ip_data_addr - BASE_ADDR;
  assign in_range = off < 32'(DEPTH_WORDS * 4);
  assign idx      = off[IDX_W+1:2];

  assign accept  = (state != WAIT);
  assign take_wr = accept & bus.ip_data_wr;
  assign take_rd = accept & bus.ip_data_rd & ~bus.ip_data_wr;

  // With a one-cycle latency the response is captured on the accepting edge itself.
  assign rd_idx      = (state == WAIT) ? idx_q : idx;
  assign rd_in_range = (state == WAIT) ? in_range_q : in_range;

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    case (state)
      IDLE, RESP: begin
        state_next = IDLE;
        if (take_rd) begin
          if (READ_LATENCY == 1) begin
            state_next = RESP;
          end else begin
            state_next = WAIT;
            cnt_next   = 3'(READ_LATENCY - 2);
          end
        end
      end
      WAIT: begin
        if (cnt == 3'd0) state_next = RESP;
        else             cnt_next   = cnt - 3'd1;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= 3'd0;
      idx_q      <= '0;
      in_range_q <= 1'b0;
      valid_q    <= 1'b0;
      data_q     <= 32'h0;
    end else begin
      state   <= state_next;
      cnt     <= cnt_next;
      valid_q <= (state_next == RESP);
      if (take_rd) begin
        idx_q      <= idx;
        in_range_q <= in_range;
      end
      // Captured before any same-edge write lands: read-before-write.
      if (state_next == RESP) data_q <= rd_in_range ? mem[rd_idx] : 32'h0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && take_wr && in_range) begin
      for (int b = 0; b < 4; b++) begin
        if (bus.ip_data_mask[b]) mem[idx][8*b +: 8] <= bus.ip_data_from_proc[8*b +: 8];
      end
    end
  end

  assign bus.op_data_valid   = valid_q;
  assign bus.op_data_to_proc = data_q;
  assign bus.op_busy         = (state == WAIT);

`ifdef DMEM_ERR_EN
  logic err_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) err_q <= 1'b0;
    else       err_q <= ((state_next == RESP) & ~rd_in_range) | (take_wr & ~in_range);
  end

  assign bus.op_data_err = err_q;
`endif

endmodule

// File: tb/tb_dmem_bridge.sv
// Three bridges (latency 1, 3, 4; one with a wrapping base) share one stimulus stream and are
// compared every cycle against a cycle-indexed behavioural model, plus literal spot checks.
module tb_dmem_bridge;

  localparam int DEPTH = 64;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] s_addr = 32'h0;
  logic        s_wr = 1'b0;
  logic [3:0]  s_mask = 4'h0;
  logic [31:0] s_data = 32'h0;
  logic        s_rd = 1'b0;
  logic        chk_en = 1'b0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  dmem_bridge_if if_a();
  dmem_bridge_if if_b();
  dmem_bridge_if if_c();

  dmem_bridge #(.DEPTH_WORDS(DEPTH), .READ_LATENCY(1), .BASE_ADDR(32'h0000_0000))
    dut_a (.clk(clk), .reset(reset), .bus(if_a));
  dmem_bridge #(.DEPTH_WORDS(DEPTH), .READ_LATENCY(3), .BASE_ADDR(32'h0000_0000))
    dut_b (.clk(clk), .reset(reset), .bus(if_b));
  dmem_bridge #(.DEPTH_WORDS(DEPTH), .READ_LATENCY(4), .BASE_ADDR(32'hFFFF_FFC0))
    dut_c (.clk(clk), .reset(reset), .bus(if_c));

  assign if_a.ip_data_addr = s_addr;  assign if_a.ip_data_wr = s_wr;  assign if_a.ip_data_mask = s_mask;
  assign if_a.ip_data_from_proc = s_data;  assign if_a.ip_data_rd = s_rd;
  assign if_b.ip_data_addr = s_addr;  assign if_b.ip_data_wr = s_wr;  assign if_b.ip_data_mask = s_mask;
  assign if_b.ip_data_from_proc = s_data;  assign if_b.ip_data_rd = s_rd;
  assign if_c.ip_data_addr = s_addr;  assign if_c.ip_data_wr = s_wr;  assign if_c.ip_data_mask = s_mask;
  assign if_c.ip_data_from_proc = s_data;  assign if_c.ip_data_rd = s_rd;

  logic        o_valid [3];
  logic [31:0] o_data  [3];
  logic        o_busy  [3];
  assign o_valid[0] = if_a.op_data_valid;  assign o_data[0] = if_a.op_data_to_proc;  assign o_busy[0] = if_a.op_busy;
  assign o_valid[1] = if_b.op_data_valid;  assign o_data[1] = if_b.op_data_to_proc;  assign o_busy[1] = if_b.op_busy;
  assign o_valid[2] = if_c.op_data_valid;  assign o_data[2] = if_c.op_data_to_proc;  assign o_busy[2] = if_c.op_busy;
`ifdef DMEM_ERR_EN
  logic o_err [3];
  assign o_err[0] = if_a.op_data_err;  assign o_err[1] = if_b.op_data_err;  assign o_err[2] = if_c.op_data_err;
`endif

  // Behavioural model: each accepted read schedules a response at an absolute cycle number.
  int          rl_tab   [3] = '{1, 3, 4};
  logic [31:0] base_tab [3] = '{32'h0000_0000, 32'h0000_0000, 32'hFFFF_FFC0};
  logic [31:0] mmem [3][DEPTH];
  int          cyc = 0;
  int          resp_at   [3];
  int          busy_last [3];
  logic [31:0] resp_data [3];
  logic        resp_err  [3];
  logic        exp_valid [3];
  logic [31:0] exp_data  [3];
  logic        exp_busy  [3];
  logic        exp_err   [3];

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int d = 0; d < 3; d++) begin
        resp_at[d]   = -1;
        busy_last[d] = -1;
        resp_data[d] = 32'h0;
        resp_err[d]  = 1'b0;
        exp_valid[d] = 1'b0;
        exp_data[d]  = 32'h0;
        exp_busy[d]  = 1'b0;
        exp_err[d]   = 1'b0;
      end
    end else begin
      cyc = cyc + 1;
      for (int d = 0; d < 3; d++) begin
        logic [31:0] off;
        logic        inr;
        logic        acc;
        logic        werr;
        int          w;
        off  = s_addr - base_tab[d];
        inr  = (off >> 2) < DEPTH;
        w    = int'(off >> 2);
        acc  = !((cyc - 1) <= busy_last[d]);
        werr = 1'b0;
        if (acc && s_wr) begin
          if (inr) begin
            for (int b = 0; b < 4; b++)
              if (s_mask[b]) mmem[d][w][8*b +: 8] = s_data[8*b +: 8];
          end else begin
            werr = 1'b1;
          end
        end else if (acc && s_rd) begin
          resp_data[d] = inr ? mmem[d][w] : 32'h0;
          resp_err[d]  = !inr;
          resp_at[d]   = cyc + rl_tab[d] - 1;
          busy_last[d] = cyc + rl_tab[d] - 2;
        end
        exp_valid[d] = (resp_at[d] == cyc);
        if (exp_valid[d]) exp_data[d] = resp_data[d];
        exp_busy[d] = (cyc <= busy_last[d]);
        exp_err[d]  = (exp_valid[d] && resp_err[d]) || werr;
      end
    end
  end

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("[TB] FAIL %s: actual=%h required=%h at %0t", name, act, exp_v, $time);
    end
  endtask

  // Per-cycle comparison against the model, sampled on the falling edge.
  always @(negedge clk) begin
    if (chk_en) begin
      for (int d = 0; d < 3; d++) begin
        check_output($sformatf("valid_%0d", d), 32'(o_valid[d]), 32'(exp_valid[d]));
        check_output($sformatf("data_%0d", d), o_data[d], exp_data[d]);
        check_output($sformatf("busy_%0d", d), 32'(o_busy[d]), 32'(exp_busy[d]));
`ifdef DMEM_ERR_EN
        check_output($sformatf("err_%0d", d), 32'(o_err[d]), 32'(exp_err[d]));
`endif
      end
    end
  end

  task automatic apply_stimulus(input logic [31:0] addr, input logic wr, input logic [3:0] mask,
                                input logic [31:0] data, input logic rd);
    s_addr = addr;  s_wr = wr;  s_mask = mask;  s_data = data;  s_rd = rd;
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic at_neg();
    @(negedge clk);
    #1;
  endtask

  initial begin
    apply_stimulus(32'h0, 1'b0, 4'h0, 32'h0, 1'b0);
    repeat (3) @(posedge clk);
    #2;
    chk_en = 1'b1;
    at_neg();
    for (int d = 0; d < 3; d++) begin
      check_output($sformatf("rst_valid_%0d", d), 32'(o_valid[d]), 32'h0);
      check_output($sformatf("rst_data_%0d", d), o_data[d], 32'h0);
      check_output($sformatf("rst_busy_%0d", d), 32'(o_busy[d]), 32'h0);
    end
    tick();
    reset = 1'b0;

    // Fill every word of every instance so later reads are fully defined.
    for (int k = 0; k < 80; k++) begin
      apply_stimulus(32'hFFFF_FFC0 + 32'(4 * k), 1'b1, 4'hF, $urandom, 1'b0);
      tick();
    end
    apply_stimulus(32'h0, 1'b0, 4'h0, 32'h0, 1'b0);
    tick();

    // Full write then read: latency 1, 3, 4.
    apply_stimulus(32'h10, 1'b1, 4'hF, 32'hDEAD_BEEF, 1'b0);  tick();
    apply_stimulus(32'h10, 1'b0, 4'h0, 32'h0, 1'b1);          tick();
    apply_stimulus(32'h0, 1'b0, 4'h0, 32'h0, 1'b0);
    at_neg();
    check_output("lat1_valid", 32'(o_valid[0]), 32'h1);
    check_output("lat1_data", o_data[0], 32'hDEAD_BEEF);
    check_output("lat3_busy0", 32'(o_busy[1]), 32'h1);
    tick();  at_neg();
    check_output("lat3_busy1", 32'(o_busy[1]), 32'h1);
    check_output("lat1_pulse_end", 32'(o_valid[0]), 32'h0);
    tick();  at_neg();
    check_output("lat3_valid", 32'(o_valid[1]), 32'h1);
    check_output("lat3_data", o_data[1], 32'hDEAD_BEEF);
    check_output("lat4_busy2", 32'(o_busy[2]), 32'h1);
    tick();  at_neg();
    check_output("lat4_valid", 32'(o_valid[2]), 32'h1);
    check_output("lat4_data", o_data[2], 32'hDEAD_BEEF);
    tick();

    // Single-lane masked write.
    apply_stimulus(32'h11, 1'b1, 4'b0010, 32'h0000_AB00, 1'b0);  tick();
    apply_stimulus(32'h10, 1'b0, 4'h0, 32'h0, 1'b1);             tick();
    apply_stimulus(32'h0, 1'b0, 4'h0, 32'h0, 1'b0);
    repeat (4) tick();
    at_neg();
    for (int d = 0; d < 3; d++) check_output($sformatf("mask_data_%0d", d), o_data[d], 32'hDEAD_ABEF);
    tick();

    // Latency 3: second read held through busy is taken only in the response cycle.
    apply_stimulus(32'h14, 1'b1, 4'hF, 32'h1111_2222, 1'b0);  tick();
    apply_stimulus(32'h10, 1'b0, 4'h0, 32'h0, 1'b1);          tick();
    apply_stimulus(32'h14, 1'b0, 4'h0, 32'h0, 1'b1);
    at_neg();  check_output("hold_busy0", 32'(o_busy[1]), 32'h1);
    tick();    at_neg();  check_output("hold_busy1", 32'(o_busy[1]), 32'h1);
    tick();    at_neg();
    check_output("hold_valid1", 32'(o_valid[1]), 32'h1);
    check_output("hold_data1", o_data[1], 32'hDEAD_ABEF);
    tick();
    apply_stimulus(32'h0, 1'b0, 4'h0, 32'h0, 1'b0);
    tick();    at_neg();  check_output("hold_no_valid", 32'(o_valid[1]), 32'h0);
    tick();    at_neg();
    check_output("hold_valid2", 32'(o_valid[1]), 32'h1);
    check_output("hold_data2", o_data[1], 32'h1111_2222);
    repeat (5) tick();

    // Simultaneous write and read: write lands, read dropped.
    apply_stimulus(32'h20, 1'b1, 4'hF, 32'h1234_5678, 1'b1);  tick();
    apply_stimulus(32'h0, 1'b0, 4'h0, 32'h0, 1'b0);
    at_neg();  check_output("wrrd_no_valid", 32'(o_valid[0]), 32'h0);
    repeat (5) tick();
    apply_stimulus(32'h20, 1'b0, 4'h0, 32'h0, 1'b1);  tick();
    apply_stimulus(32'h0, 1'b0, 4'h0, 32'h0, 1'b0);
    repeat (4) tick();
    at_neg();
    for (int d = 0; d < 3; d++) check_output($sformatf("wrrd_data_%0d", d), o_data[d], 32'h1234_5678);
    tick();

    // Out-of-range read just past the array.
    apply_stimulus(32'h100, 1'b0, 4'h0, 32'h0, 1'b1);  tick();
    apply_stimulus(32'h0, 1'b0, 4'h0, 32'h0, 1'b0);
    at_neg();
    check_output("oor_valid", 32'(o_valid[0]), 32'h1);
    check_output("oor_data", o_data[0], 32'h0);
`ifdef DMEM_ERR_EN
    check_output("oor_err", 32'(o_err[0]), 32'h1);
`endif
    repeat (4) tick();

    // Reset two cycles into a latency-4 read.
    apply_stimulus(32'h10, 1'b0, 4'h0, 32'h0, 1'b1);  tick();
    apply_stimulus(32'h0, 1'b0, 4'h0, 32'h0, 1'b0);
    tick();  tick();
    reset = 1'b1;
    at_neg();
    check_output("rstmid_busy", 32'(o_busy[2]), 32'h0);
    check_output("rstmid_data", o_data[2], 32'h0);
    tick();
    reset = 1'b0;
    for (int k = 0; k < 4; k++) begin
      at_neg();
      check_output("rstmid_no_valid", 32'(o_valid[2]), 32'h0);
      tick();
    end
    apply_stimulus(32'h10, 1'b0, 4'h0, 32'h0, 1'b1);  tick();
    apply_stimulus(32'h0, 1'b0, 4'h0, 32'h0, 1'b0);
    repeat (3) tick();
    at_neg();
    check_output("rstmid_keep_valid", 32'(o_valid[2]), 32'h1);
    check_output("rstmid_keep_data", o_data[2], 32'hDEAD_ABEF);
    tick();

    // Randomised traffic, including wrapping/out-of-range addresses and rare resets.
    for (int n = 0; n < 2500; n++) begin
      int r;
      r = int'($urandom_range(0, 15));
      reset = ($urandom_range(0, 299) == 0);
      apply_stimulus(32'($urandom_range(0, 32'h2FF)) - 32'h100, (r < 5) || (r == 11),
                     4'($urandom), $urandom, (r >= 5) && (r <= 11));
      tick();
    end
    reset = 1'b0;
    apply_stimulus(32'h0, 1'b0, 4'h0, 32'h0, 1'b0);
    repeat (8) tick();
    at_neg();
    chk_en = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
